// File: rtl/decoder_scan_nto2n.sv
// Registered one-hot decoder with direct-select and auto-scan modes.
// All outputs come straight from flops so the strobes are glitch-free.
module decoder_scan_nto2n #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             err,
  output logic             wrap
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(N_OUT - 1);

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             sel_ok;
  logic             line_on;

  // Extra bit so N_OUT == 2**SEL_W is representable in the compare.
  assign sel_ok = ({1'b0, sel} < (SEL_W + 1)'(N_OUT));

  always_comb begin
    state_d = StIdle;
    cnt_d   = '0;
    idx_d   = '0;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    line_on = 1'b0;

    if (ena) begin
      if (!mode) begin
        state_d = StDirect;
        if (sel_ok) begin
          idx_d   = sel;
          line_on = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        state_d = StScan;
        line_on = 1'b1;
        if (state_q != StScan) begin
          // Entry cycle counts as dwell cycle 0.
          idx_d = sel_ok ? sel : '0;
        end else if (cnt_q == CntLast) begin
          if (idx_q == IdxLast) begin
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q;
        end
      end
    end

    out_d = line_on ? (N_OUT'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign err  = err_q;
  assign wrap = wrap_q;

endmodule

// File: doc/decoder_scan_nto2n.md
# decoder_scan_nto2n

Parametrised, registered one-hot decoder: successor to the combinational 3-to-8 decoder with enable. Generalises select width and output count, adds range checking on the select, and adds an auto-scan mode that walks the active output across all lines with a programmable dwell time. It drives digit or row strobes in display and multiplexing paths; all outputs are registered for glitch-free strobes.

## Interface
- `SEL_W`, default 3: select width.
- `N_OUT`, default 8: number of output lines; legal range 2..2**SEL_W.
- `DWELL`, default 4: cycles each line stays active in scan mode; ≥1.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `ena` input, 1 bit: block enable; 0 forces the idle state.
- `mode` input, 1 bit: 0 = direct decode, 1 = auto-scan.
- `sel` input, `SEL_W` bits: line index in direct mode; start index on scan entry.
- `out` output, `N_OUT` bits: one-hot or all-zero strobe vector.
- `idx` output, `SEL_W` bits: index of the active line; 0 when no line is active.
- `err` output, 1 bit: direct-mode select out of range (`sel` ≥ `N_OUT`).
- `wrap` output, 1 bit: one-cycle pulse when scan moves from `N_OUT`-1 to 0.

## Operation
- **States:** IDLE, DIRECT, SCAN. State is registered; the next state is taken from `ena` and `mode` each cycle.
  - `ena`=0 → IDLE.
  - `ena`=1, `mode`=0 → DIRECT.
  - `ena`=1, `mode`=1 → SCAN.
- **IDLE:** `out`=0, `idx`=0, `err`=0, `wrap`=0. The dwell counter is cleared.
- **DIRECT:** each cycle, sample `sel`.
  - `sel` < `N_OUT`: `out` ← 1<<`sel`, `idx` ← `sel`, `err` ← 0.
  - Otherwise: `out` ← 0, `idx` ← 0, `err` ← 1.
- **SCAN entry** (first cycle in SCAN from IDLE or DIRECT):
  - `idx` ← `sel` if `sel` < `N_OUT`, else 0.
  - Dwell counter ← 0.
  - `err` ← 0.
- **SCAN steady state:**
  - `out` = 1<<`idx`.
  - The dwell counter increments each cycle.
  - When the counter reaches `DWELL`-1, it returns to 0 and `idx` advances.
  - The advance from `N_OUT`-1 wraps to 0 and asserts `wrap` for exactly that cycle.
  - `err` is always 0 in SCAN.
- **Invariant:** `out` is always one-hot or all-zero, never multi-hot.
- **Counter widths:** `idx` is `SEL_W` bits. The dwell counter is $clog2(`DWELL`) bits, minimum 1. The `idx` comparison against `N_OUT`-1 is explicit, so non-power-of-two `N_OUT` wraps correctly.
- **`DWELL`=1:** `idx` advances every cycle.
- **SCAN → DIRECT:** the next cycle decodes `sel`. Scan position is not retained.
- **DIRECT → SCAN:** re-enters through the SCAN entry rule.
- **Changing `sel` during SCAN:** ignored.

## Timing
- **Reset:** `rst_n` low asynchronously forces state IDLE, `out`=0, `idx`=0, `err`=0, `wrap`=0, dwell counter 0. This applies in any state, including mid-scan. Reset release is synchronous to `clk`, and the first decision is taken on the first rising edge with `rst_n`=1.
- **Latency:** one cycle from `ena`/`mode`/`sel` at edge k to `out`/`idx`/`err` after edge k.
- **Simultaneous `ena` fall and scan wrap:** IDLE wins; `wrap` stays 0.
- **Scan period:** `N_OUT`×`DWELL` cycles per full revolution. `wrap` asserts once per revolution, in the cycle where `idx` becomes 0.
- **Scan entry:** the first active line holds for a full `DWELL` cycles, with the entry cycle counted as dwell cycle 0.

## Test plan
Parameters: `SEL_W`=3, `N_OUT`=6, `DWELL`=2 unless stated.
- **Reset / idle:** hold `rst_n`=0, then release with `ena`=0 → `out`=000000, `idx`=0, `err`=0, `wrap`=0 on every cycle.
- **Direct sweep:** `ena`=1, `mode`=0, `sel`=0..5 one per cycle → `out`=000001, 000010 … 100000, each one cycle late; `idx` equals the prior `sel`; `err`=0.
- **Out-of-range select:** `sel`=6, then 7 → `out`=0, `idx`=0, `err`=1. Then `sel`=2 → `out`=000100, `err`=0.
- **Scan from a start index:** `mode`=1, `sel`=4, run 14 cycles → `idx` sequence 4,4,5,5,0,0,1,1,2,2,3,3,4,4. `wrap`=1 only on the first cycle with `idx`=0. `out` matches `idx`.
- **Scan entry with invalid select, `DWELL`=1:** `sel`=7 → `idx` starts at 0 and advances each cycle 0..5,0. `wrap` pulses each 6 cycles. `err`=0.
- **Reset mid-scan and `ena` drop:**
  - Drop `rst_n` asynchronously at `idx`=3 → all outputs 0 immediately.
  - Separately, drop `ena` on a wrap cycle → `out`=0 and `wrap`=0 on the next cycle.
  - Re-enable in direct mode with `sel`=1 → `out`=000010.
